wallace_csa_pipe: RTL
=====================

// Module: wallace_csa_pipe
// PURPOSE
//  Pipelined Wallace-tree front end of the multiplier: accepts two WIDTH-bit unsigned operands.
//  Generates WIDTH partial-product rows and reduces them with 3:2 carry-save adders to two
//  2*WIDTH-bit rows (sum_row, carry_row) whose modular sum equals a*b.
//  Sits directly upstream of the carry-lookahead final adder, which consumes sum_row/carry_row.
//  Three register stages with valid/ready flow control and a pass-through tag.
// PARAMETERS
//  WIDTH      32  operand width; rows are 2*WIDTH bits (64 at default, matching the final adder)
//  TAG_W      4   width of the user tag carried alongside each operation
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand pair present on op_a/op_b/in_tag
//  in_ready   out  1        block accepts the pair this cycle (transfer = in_valid & in_ready)
//  op_a       in   WIDTH    multiplicand, unsigned
//  op_b       in   WIDTH    multiplier, unsigned
//  in_tag     in   TAG_W    user tag, returned unchanged with the result
//  out_valid  out  1        sum_row/carry_row/out_tag hold a result
//  out_ready  in   1        final adder consumes the result (transfer = out_valid & out_ready)
//  sum_row    out  2*WIDTH  reduced sum row
//  carry_row  out  2*WIDTH  reduced carry row, already shifted to its bit weight
//  out_tag    out  TAG_W    tag of the result on sum_row/carry_row
// BEHAVIOUR
//  Stages: S1 registers the WIDTH partial-product rows pp[i] = (op_a & {WIDTH{op_b[i]}}) << i.
//   S2 applies CSA levels 1-4 (32->22->15->10->7 rows at default) and registers 7 rows.
//   S3 applies levels 5-8 (7->5->4->3->2) and registers the two output rows.
//   For other WIDTH: first half of Wallace levels (floor) in S2, remainder in S3.
//  CSA: s = x^y^z, c = (x&y|x&z|y&z) << 1. Leftover rows (count mod 3) pass through unchanged.
//   All rows are 2*WIDTH bits. Bits shifted beyond bit 2*WIDTH-1 are dropped, so the required
//   invariant is (sum_row + carry_row) mod 2^(2*WIDTH) == op_a*op_b, the exact product.
//  Per-stage valid bits v1,v2,v3. out_valid = v3. The tag travels with its data in each stage.
//  Advance rules, evaluated every cycle:
//   S3 loads from S2 when v2 & (!v3 | out_ready).
//   S2 loads from S1 when v1 & (!v2 | S3 loads).
//   S1 loads inputs when in_valid & in_ready.
//   in_ready = !v1 | S2 loads (combinational from out_ready through the valid chain).
//   A stage that is emptied and not refilled clears its valid bit.
//   A stage with valid=1 that cannot advance holds its data and tag unchanged.
//  Latency 3 cycles from accepted input to out_valid with no stall. Throughput 1 per cycle.
//  Full pipeline with out_ready=0: in_ready=0 and all three stages hold.
//   Release: out_ready=1 drains one result per cycle and takes a new input in that same cycle.
//  Simultaneous accept at S1 and emit at S3 in one cycle is legal; no bubble is inserted.
//  Outputs may change only when out_valid=0 or a transfer occurs (stable while stalled).
//  Reset (asynchronous, any time including mid-operation):
//   v1=v2=v3=0, out_valid=0, sum_row=0, carry_row=0, out_tag=0.
//   in-flight operations are discarded. in_ready=1 in the first cycle after reset deasserts.
//  Datapath registers need no reset beyond the outputs listed; they are don't-care while valid=0.
// TESTING
//  op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, tag=0x5, out_ready=1 -> out_valid 3 cycles later;
//   sum_row+carry_row = 0xFFFFFFFE00000001; out_tag=0x5.
//  op_a=0, op_b=0x12345678 -> sum_row=0, carry_row=0.
//   op_a=1, op_b=0x80000000 -> sum_row+carry_row = 0x0000000080000000.
//  Eight back-to-back inputs, tags 0..7, out_ready=1 -> eight consecutive out_valid cycles.
//   Results arrive in order, tags 0..7, in_ready stays 1 throughout.
//  Hold out_ready=0 while feeding 5 inputs -> exactly 3 accepted, in_ready=0 afterwards.
//   Outputs stay stable. Then out_ready=1 -> 3 results drain in order; 4th input accepted on
//   the first drain cycle.
//  Assert rst with 2 operations in flight -> out_valid=0 and rows=0 immediately (async).
//   No stale result appears after release. Next input yields out_valid after exactly 3 cycles.
//  10k random operand pairs with random in_valid/out_ready -> every result matches a*b mod 2^64.
//   Tag order is preserved; no drop or duplicate; no output change while stalled.

Source files
------------

// File: rtl/wallace_csa_pipe.sv
// wallace_csa_pipe: three-stage Wallace-tree carry-save reducer of a*b into sum/carry rows.
// Requires WIDTH >= 4 so that each of the two reduction stages gets at least one CSA level.
module wallace_csa_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] sum_row,
   output logic [2*WIDTH-1:0] carry_row,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int W2 = 2 * WIDTH;

   function automatic int rows_at(input int l);
      int n;
      n = WIDTH;
      for (int i = 0; i < l; i++) n = n - n / 3;
      return n;
   endfunction

   function automatic int num_levels();
      int n;
      int l;
      n = WIDTH;
      l = 0;
      while (n > 2) begin
         n = n - n / 3;
         l++;
      end
      return l;
   endfunction

   localparam int LV = num_levels();
   localparam int L1 = LV / 2;
   localparam int C2 = rows_at(L1);

   logic [W2-1:0]    p1   [WIDTH];
   logic [W2-1:0]    p2   [C2];
   logic [W2-1:0]    lin  [LV][WIDTH];
   logic [W2-1:0]    lout [LV][WIDTH];
   logic [TAG_W-1:0] t1, t2;
   logic             v1, v2, v3, ld1, ld2, ld3;

   assign ld3       = v2 & (!v3 | out_ready);
   assign ld2       = v1 & (!v2 | ld3);
   assign in_ready  = !v1 | ld2;
   assign ld1       = in_valid & in_ready;
   assign out_valid = v3;

   // Level l reads S1 rows, S2 rows at the stage split, otherwise the previous level.
   for (genvar l = 0; l < LV; l++) begin : lvl
      localparam int N = rows_at(l);
      localparam int G = N / 3;
      for (genvar k = 0; k < WIDTH; k++) begin : row
         if (l == 0) begin : src_s1
            assign lin[l][k] = p1[k];
         end else if (l == L1) begin : src_s2
            if (k < C2) begin : used
               assign lin[l][k] = p2[k];
            end else begin : unused
               assign lin[l][k] = '0;
            end
         end else begin : src_prev
            assign lin[l][k] = lout[l-1][k];
         end
         if (k < G) begin : csa_s
            assign lout[l][k] = lin[l][3*k] ^ lin[l][3*k+1] ^ lin[l][3*k+2];
         end else if (k < 2 * G) begin : csa_c
            assign lout[l][k] = ((lin[l][3*(k-G)] & lin[l][3*(k-G)+1])
                               | (lin[l][3*(k-G)] & lin[l][3*(k-G)+2])
                               | (lin[l][3*(k-G)+1] & lin[l][3*(k-G)+2])) << 1;
         end else if (k < N - G) begin : pass
            assign lout[l][k] = lin[l][k+G];
         end else begin : empty
            assign lout[l][k] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ld1) begin
         for (int i = 0; i < WIDTH; i++) p1[i] <= W2'(op_a & {WIDTH{op_b[i]}}) << i;
         t1 <= in_tag;
      end
      if (ld2) begin
         for (int i = 0; i < C2; i++) p2[i] <= lout[L1-1][i];
         t2 <= t1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         sum_row   <= '0;
         carry_row <= '0;
         out_tag   <= '0;
      end else begin
         v1 <= ld1 | (v1 & !ld2);
         v2 <= ld2 | (v2 & !ld3);
         v3 <= ld3 | (v3 & !out_ready);
         if (ld3) begin
            sum_row   <= lout[LV-1][0];
            carry_row <= lout[LV-1][1];
            out_tag   <= t2;
         end
      end
   end
endmodule
